// File: rtl/cnn_pkg.sv
// Shared CNN constants and the frame sequencer state encoding.
package cnn_pkg;
  localparam int CNN_H         = 24;
  localparam int CNN_W         = 24;
  localparam int CNN_DATA_BITS = 8;
  localparam int CNN_CLASSES   = 7;

  typedef enum logic [2:0] {
    SEQ_IDLE        = 3'd0,
    SEQ_FETCH       = 3'd1,
    SEQ_PUSH        = 3'd2,
    SEQ_WAIT_CREDIT = 3'd3,
    SEQ_DRAIN       = 3'd4
  } seq_state_e;
endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// Frame sequencer bus: host/row-memory/line-buffer/conv/dense signals.
interface cnn_frame_sequencer_if
  import cnn_pkg::*;
#(
  parameter int H        = CNN_H,
  parameter int ROW_BITS = CNN_W * CNN_DATA_BITS,
  parameter int OUT_BITS = CNN_CLASSES * CNN_DATA_BITS
);
  localparam int AW = $clog2(H);

  logic                frame_start_i;
  logic                frame_ready_o;
  logic                row_req_o;
  logic [AW-1:0]       row_addr_o;
  logic                row_valid_i;
  logic [ROW_BITS-1:0] row_data_i;
  logic [ROW_BITS-1:0] lb_data_o;
  logic                lb_valid_o;
  logic                conv1_done_i;
  logic                dense_valid_i;
  logic [OUT_BITS-1:0] dense_data_i;
  logic [OUT_BITS-1:0] result_o;
  logic                result_valid_o;
  logic                busy_o;
  logic [15:0]         frame_cnt_o;
  logic                err_o;

  modport master (
    input  frame_start_i, row_valid_i, row_data_i, conv1_done_i, dense_valid_i, dense_data_i,
    output frame_ready_o, row_req_o, row_addr_o, lb_data_o, lb_valid_o,
           result_o, result_valid_o, busy_o, frame_cnt_o, err_o
  );

  modport slave (
    output frame_start_i, row_valid_i, row_data_i, conv1_done_i, dense_valid_i, dense_data_i,
    input  frame_ready_o, row_req_o, row_addr_o, lb_data_o, lb_valid_o,
           result_o, result_valid_o, busy_o, frame_cnt_o, err_o
  );
endinterface

// File: rtl/seq_credit_counter.sv
// Up/down saturating credit counter; ovf flags an increment dropped at MAX.
module seq_credit_counter #(
  parameter int MAX  = 2,
  parameter int INIT = MAX,
  parameter int W    = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         ovf
);
  logic at_max, at_zero;

  assign at_max  = count == W'(MAX);
  assign at_zero = count == '0;
  assign ovf     = inc && !dec && at_max;

  // simultaneous inc and dec cancel out
  always_ff @(posedge clk) begin
    if (!resetn || clr)               count <= W'(INIT);
    else if (inc && !dec && !at_max)  count <= count + 1'b1;
    else if (dec && !inc && !at_zero) count <= count - 1'b1;
  end
endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer: credit-paced row fetch into the line buffer, dense capture.
// Optional watchdog: define CNN_FRAME_SEQUENCER_WATCHDOG_EN (adds TIMEOUT).
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int H          = CNN_H,
  parameter int ROW_BITS   = CNN_W * CNN_DATA_BITS,
  parameter int PRIME_ROWS = 2,
  parameter int OUT_BITS   = CNN_CLASSES * CNN_DATA_BITS
`ifdef CNN_FRAME_SEQUENCER_WATCHDOG_EN
  , parameter int TIMEOUT  = 65535
`endif
) (
  input  logic                   clk,
  input  logic                   resetn,
  cnn_frame_sequencer_if.master  bus
);
  localparam int AW = $clog2(H);
  localparam int CW = $clog2(PRIME_ROWS + 1);

  seq_state_e          state_q, state_n;
  logic [AW-1:0]       row_q, row_n;
  logic [ROW_BITS-1:0] lb_data_q;
  logic [OUT_BITS-1:0] result_q;
  logic                res_vld_q;
  logic [15:0]         frame_cnt_q;
  logic                err_q;
  logic [CW-1:0]       credit;
  logic                credit_ovf, push, capture, timeout, err_set;

  assign push    = state_q == SEQ_PUSH;
  assign capture = (state_q == SEQ_DRAIN) && bus.dense_valid_i;

`ifdef CNN_FRAME_SEQUENCER_WATCHDOG_EN
  logic [15:0] wd_q;
  logic        wd_run, wd_evt;

  assign wd_run  = state_q inside {SEQ_FETCH, SEQ_WAIT_CREDIT, SEQ_DRAIN};
  assign wd_evt  = bus.row_valid_i || bus.conv1_done_i || bus.dense_valid_i;
  assign timeout = wd_run && !wd_evt && (wd_q == 16'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!resetn || !wd_run || wd_evt || state_n != state_q) wd_q <= '0;
    else                                                     wd_q <= wd_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  seq_credit_counter #(.MAX(PRIME_ROWS), .INIT(PRIME_ROWS), .W(CW)) u_credit (
    .clk    (clk),
    .resetn (resetn),
    .clr    (capture || timeout),
    .inc    (bus.conv1_done_i),
    .dec    (push),
    .count  (credit),
    .ovf    (credit_ovf)
  );

  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    unique case (state_q)
      SEQ_IDLE:  if (bus.frame_start_i) state_n = SEQ_FETCH;
      SEQ_FETCH: if (bus.row_valid_i)   state_n = SEQ_PUSH;
      SEQ_PUSH: begin
        if (row_q == AW'(H - 1)) state_n = SEQ_DRAIN;
        else begin
          row_n = row_q + 1'b1;
          // post-update credit: this push spends one, a same-cycle done returns one
          state_n = (credit > CW'(1) || bus.conv1_done_i) ? SEQ_FETCH : SEQ_WAIT_CREDIT;
        end
      end
      SEQ_WAIT_CREDIT: if (credit != '0) state_n = SEQ_FETCH;
      SEQ_DRAIN:       if (bus.dense_valid_i) state_n = SEQ_IDLE;
      default:         state_n = SEQ_IDLE;
    endcase
    if (timeout) state_n = SEQ_IDLE;
    if (state_n == SEQ_IDLE) row_n = '0;
  end

  assign err_set = credit_ovf
                || (bus.conv1_done_i  && state_q == SEQ_IDLE)
                || (bus.dense_valid_i && state_q != SEQ_DRAIN)
                || (bus.row_valid_i   && state_q != SEQ_FETCH)
                || timeout;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= SEQ_IDLE;
      row_q       <= '0;
      lb_data_q   <= '0;
      result_q    <= '0;
      res_vld_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_n;
      row_q     <= row_n;
      res_vld_q <= capture;
      if (state_q == SEQ_FETCH && bus.row_valid_i) lb_data_q <= bus.row_data_i;
      if (capture) begin
        result_q    <= bus.dense_data_i;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.frame_ready_o  = state_q == SEQ_IDLE;
  assign bus.busy_o         = state_q != SEQ_IDLE;
  assign bus.row_req_o      = state_q == SEQ_FETCH;
  assign bus.row_addr_o     = row_q;
  assign bus.lb_valid_o     = push;
  assign bus.lb_data_o      = lb_data_q;
  assign bus.result_o       = result_q;
  assign bus.result_valid_o = res_vld_q;
  assign bus.frame_cnt_o    = frame_cnt_q;
  assign bus.err_o          = err_q;
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: row memory and conv1 models, directed frames.
module tb_cnn_frame_sequencer;
  import cnn_pkg::*;
  localparam int H = 24, ROW_BITS = 192, OUT_BITS = 56, AW = 5;

  typedef struct { int addr; logic [ROW_BITS-1:0] data; } row_exp_t;

  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;

  logic                start = 0, mem_vld = 0, man_done = 0, auto_done = 0, dvld = 0;
  logic [ROW_BITS-1:0] mem_data = '0;
  logic [OUT_BITS-1:0] ddata = '0;
  logic                mem_en = 1, auto_en = 0, mem_req_prev = 0;
  logic [4:0]          dl = '0;

  row_exp_t            rowq[$];
  logic [OUT_BITS-1:0] resq[$];
  int checks = 0, errors = 0, pushes_seen = 0, results_seen = 0;

  cnn_frame_sequencer_if #(.H(H), .ROW_BITS(ROW_BITS), .OUT_BITS(OUT_BITS)) bus ();

  assign bus.frame_start_i = start;
  assign bus.row_valid_i   = mem_vld;
  assign bus.row_data_i    = mem_data;
  assign bus.conv1_done_i  = man_done | auto_done;
  assign bus.dense_valid_i = dvld;
  assign bus.dense_data_i  = ddata;

  cnn_frame_sequencer #(.H(H), .ROW_BITS(ROW_BITS), .PRIME_ROWS(2), .OUT_BITS(OUT_BITS)
`ifdef CNN_FRAME_SEQUENCER_WATCHDOG_EN
    , .TIMEOUT(100)
`endif
  ) dut (.clk(clk), .resetn(resetn), .bus(bus));

  function automatic logic [ROW_BITS-1:0] mkrow(input int r);
    logic [ROW_BITS-1:0] v;
    for (int p = 0; p < 24; p++) v[p*8 +: 8] = 8'(r * 24 + p + 1);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [ROW_BITS-1:0] act, input logic [ROW_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic queue_frame();
    for (int r = 0; r < H; r++) rowq.push_back('{r, mkrow(r)});
  endtask

  task automatic start_frame();
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_pushes(input int target, input string nm);
    int c = 0;
    while (pushes_seen < target && c < 3000) begin tick(); c++; end
    if (pushes_seen < target) begin
      checks++; errors++;
      $display("FAIL %s: pushes %0d expected %0d (cycle limit)", nm, pushes_seen, target);
    end
  endtask

  task automatic finish_frame(input logic [OUT_BITS-1:0] d, input int cnt);
    dvld = 1; ddata = d; resq.push_back(d);
    tick(); dvld = 0;
    @(negedge clk);
    chk("result_pulse", bus.result_valid_o, 1);
    chk("ready_with_result", bus.frame_ready_o, 1);
    chk("frame_cnt", bus.frame_cnt_o, cnt);
    @(posedge clk); #1;
  endtask

  // row memory: answers a held request one cycle after it is first seen
  initial forever begin
    @(posedge clk); #1;
    if (mem_vld) mem_vld = 0;
    else if (mem_en && mem_req_prev && bus.row_req_o) begin
      mem_vld  = 1;
      mem_data = mkrow(int'(bus.row_addr_o));
    end
    mem_req_prev = bus.row_req_o && !mem_vld;
  end

  // conv1 model: a done pulse about 5 cycles after each push of row 1 onwards
  initial forever begin
    @(negedge clk);
    dl = {dl[3:0], auto_en && bus.lb_valid_o && bus.row_addr_o != '0};
    if (!resetn) dl = '0;
    auto_done = dl[4];
  end

  // monitor: pops the scoreboard whenever the DUT presents a push or a result
  always @(negedge clk) begin
    row_exp_t e;
    if (bus.lb_valid_o) begin
      pushes_seen++;
      if (rowq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_push: row %0d pushed, none expected", bus.row_addr_o);
      end else begin
        e = rowq.pop_front();
        chk("push_addr", bus.row_addr_o, e.addr);
        chk("push_data", bus.lb_data_o, e.data);
      end
    end
    if (bus.result_valid_o) begin
      results_seen++;
      if (resq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: result %0h, none expected", bus.result_o);
      end else chk("result_data", bus.result_o, resq.pop_front());
    end
  end

  initial begin
    int base, c;
    tick(2);
    @(negedge clk);
    chk("rst_ready", bus.frame_ready_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_req", bus.row_req_o, 0);
    chk("rst_lbvalid", bus.lb_valid_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_cnt", bus.frame_cnt_o, 0);
    @(posedge clk); #1; resetn = 1;

    // nominal frame
    queue_frame(); auto_en = 1; base = pushes_seen;
    start_frame();
    @(negedge clk);
    chk("busy_after_start", bus.busy_o, 1);
    chk("ready_after_start", bus.frame_ready_o, 0);
    @(posedge clk); #1;
    wait_pushes(base + 24, "nominal_pushes");
    tick(10);
    finish_frame(56'h02030405060708, 1);
    @(negedge clk);
    chk("nominal_err", bus.err_o, 0);
    chk("nominal_busy", bus.busy_o, 0);
    @(posedge clk); #1;

    // credit stall, busy start, then coincident push/done
    queue_frame(); auto_en = 0; base = pushes_seen;
    start_frame(); tick(20);
    @(negedge clk);
    chk("stall_pushes", pushes_seen - base, 2);
    chk("stall_req", bus.row_req_o, 0);
    @(posedge clk); #1; start_frame();
    @(negedge clk);
    chk("busy_start_err", bus.err_o, 0);
    chk("busy_start_req", bus.row_req_o, 0);
    @(posedge clk); #1; man_done = 1; tick(); man_done = 0;
    @(negedge clk); chk("credit_req_1cyc", bus.row_req_o, 0);
    @(posedge clk); @(negedge clk); chk("credit_req_2cyc", bus.row_req_o, 1);
    @(posedge clk); #1; @(posedge clk); #1; man_done = 1;
    @(negedge clk); chk("coincident_push", bus.lb_valid_o, 1);
    @(posedge clk); #1; man_done = 0;
    @(negedge clk); chk("no_extra_stall", bus.row_req_o, 1);
    @(posedge clk); #1; auto_en = 1;
    wait_pushes(base + 24, "stall_frame_pushes");
    tick(10);
    finish_frame(56'hA55A0123456789, 2);

    // reset mid-frame at row 10
    queue_frame(); start_frame(); c = 0;
    @(negedge clk);
    while (!(bus.row_req_o && bus.row_addr_o == AW'(10)) && c < 600) begin @(negedge clk); c++; end
    chk("reach_row10", bus.row_addr_o, 10);
    @(posedge clk); #1; resetn = 0; tick(); resetn = 1;
    @(negedge clk);
    chk("midrst_ready", bus.frame_ready_o, 1);
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_req", bus.row_req_o, 0);
    chk("midrst_addr", bus.row_addr_o, 0);
    chk("midrst_lbdata", bus.lb_data_o, 0);
    chk("midrst_result", bus.result_o, 0);
    chk("midrst_cnt", bus.frame_cnt_o, 0);
    @(posedge clk); #1;
    rowq.delete(); queue_frame(); base = pushes_seen;
    start_frame();
    wait_pushes(base + 24, "restart_pushes");
    tick(10);
    finish_frame(56'h11223344556677, 1);

    // protocol errors
    @(negedge clk); chk("pre_err", bus.err_o, 0);
    @(posedge clk); #1; dvld = 1; ddata = 56'hDEADBEEF000001; tick(); dvld = 0;
    @(negedge clk);
    chk("dense_idle_err", bus.err_o, 1);
    chk("dense_idle_cnt", bus.frame_cnt_o, 1);
    @(posedge clk); #1; tick(3);
    @(negedge clk); chk("err_sticky", bus.err_o, 1);
    @(posedge clk); #1; resetn = 0; tick(2); resetn = 1;
    @(negedge clk); chk("err_cleared", bus.err_o, 0);
    @(posedge clk); #1; mem_en = 0; auto_en = 0;
    start_frame();
    @(negedge clk);
    chk("fetch_req", bus.row_req_o, 1);
    chk("fetch_err", bus.err_o, 0);
    @(posedge clk); #1; man_done = 1; tick(); man_done = 0;
    @(negedge clk);
    chk("full_credit_err", bus.err_o, 1);
    chk("fetch_req_held", bus.row_req_o, 1);
    chk("fetch_addr_held", bus.row_addr_o, 0);
    @(posedge clk); #1; resetn = 0; tick(); resetn = 1; mem_en = 1;

`ifdef CNN_FRAME_SEQUENCER_WATCHDOG_EN
    queue_frame(); auto_en = 1; base = pushes_seen;
    start_frame();
    wait_pushes(base + 24, "wd_pushes");
    tick(50);
    @(negedge clk);
    chk("wd_early_err", bus.err_o, 0);
    chk("wd_early_busy", bus.busy_o, 1);
    c = 0;
    while (!bus.frame_ready_o && c < 200) begin @(negedge clk); c++; end
    chk("wd_idle", bus.frame_ready_o, 1);
    chk("wd_err", bus.err_o, 1);
    chk("wd_cnt", bus.frame_cnt_o, 0);
    @(posedge clk); #1; tick(5);
`endif

    @(negedge clk);
    chk("rows_drained", rowq.size(), 0);
    chk("results_drained", resq.size(), 0);
    chk("result_pulses", results_seen, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
